// File: rtl/pic_pkg.sv
// Shared definitions for the 8259 priority resolver: acknowledge phases and
// the rotating-priority rank helper.
package pic_pkg;

  localparam logic ACK_IDLE  = 1'b0;
  localparam logic ACK_FIRST = 1'b1;

  // Rank 0 is the highest priority: the level just after lowest_prio.
  function automatic logic [2:0] prio_rank(input logic [2:0] level,
                                           input logic [2:0] lowest_prio);
    return level - lowest_prio - 3'd1;
  endfunction

endpackage

// File: rtl/pic_priority_encoder.sv
// Combinational rotating-priority encoder: returns the highest-priority set bit
// of vec, where priority starts just after lowest_prio and wraps.
module pic_priority_encoder
  import pic_pkg::*;
(
  input  logic [7:0] vec,
  input  logic [2:0] lowest_prio,
  output logic       valid,
  output logic [2:0] level
);

  logic [2:0] idx;

  // Scan from lowest to highest priority so the last hit is the winner.
  always_comb begin
    valid = 1'b0;
    level = 3'd0;
    idx   = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      idx = lowest_prio + 3'd1 + 3'(k);
      if (vec[idx]) begin
        valid = 1'b1;
        level = idx;
      end
    end
  end

endmodule

// File: rtl/pic_priority_resolver.sv
// 8259 IRR/ISR holder and priority resolver: request sensing, fully-nested
// arbitration, INTA_ sequencing, and EOI / priority-rotation commands.
module pic_priority_resolver
  import pic_pkg::*;
#(
  parameter int NUM_IR = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [NUM_IR-1:0] IR,
  input  logic              LEVEL,
  input  logic [NUM_IR-1:0] interrupt_mask,
  input  logic              INTA_,
  input  logic              AEOI,
  input  logic              R,
  input  logic              EOI_CMD,
  input  logic              SEOI,
  input  logic              ROTATE,
  input  logic              PRIO_CMD,
  input  logic [2:0]        EOI_LEVEL,
  output logic              INTERNAL_INT,
  output logic [2:0]        IR_NUM,
  output logic [NUM_IR-1:0] IRR_OUT,
  output logic [NUM_IR-1:0] ISR_OUT
);

  logic [NUM_IR-1:0] irr_q, irr_d, isr_q, isr_d, ir_prev_q, ir_prev_d;
  logic              inta_prev_q, inta_prev_d, ack_q, ack_d, spur_q, spur_d;
  logic              int_q, int_d;
  logic [2:0]        ir_num_q, ir_num_d, lp_q, lp_d;

  logic [NUM_IR-1:0] pend, sense, isr_set, isr_clr;
  logic              pend_vld, isr_vld, fall, req, eoi_rot, aeoi_rot;
  logic [2:0]        hp_pend, hp_isr, rot_lvl;

  assign pend = irr_q & ~interrupt_mask;

  pic_priority_encoder u_pend_enc (
    .vec         (pend),
    .lowest_prio (lp_q),
    .valid       (pend_vld),
    .level       (hp_pend)
  );

  pic_priority_encoder u_isr_enc (
    .vec         (isr_q),
    .lowest_prio (lp_q),
    .valid       (isr_vld),
    .level       (hp_isr)
  );

  always_comb begin
    fall        = inta_prev_q & ~INTA_;
    req         = pend_vld & (~isr_vld |
                  (prio_rank(hp_pend, lp_q) < prio_rank(hp_isr, lp_q)));
    int_d       = req & (ack_q == ACK_IDLE);
    ir_prev_d   = IR;
    inta_prev_d = INTA_;
    ack_d       = ack_q;
    spur_d      = spur_q;
    ir_num_d    = ir_num_q;
    isr_set     = '0;
    isr_clr     = '0;
    eoi_rot     = 1'b0;
    aeoi_rot    = 1'b0;
    rot_lvl     = 3'd0;
    lp_d        = lp_q;

    // A request that drops before acknowledge is forgotten in either mode.
    sense = LEVEL ? IR : (IR & ~ir_prev_q);
    irr_d = (irr_q | sense) & IR;

    if (fall) begin
      if (ack_q == ACK_IDLE) begin
        ack_d = ACK_FIRST;
        if (pend_vld) begin
          ir_num_d         = hp_pend;
          isr_set[hp_pend] = 1'b1;
          irr_d[hp_pend]   = 1'b0;
          spur_d           = 1'b0;
        end else begin
          ir_num_d = 3'd7;
          spur_d   = 1'b1;
        end
      end else begin
        ack_d = ACK_IDLE;
        if (AEOI && !spur_q) begin
          isr_clr[ir_num_q] = 1'b1;
          aeoi_rot          = R;
        end
      end
    end

    if (EOI_CMD) begin
      if (SEOI) begin
        isr_clr[EOI_LEVEL] = 1'b1;
        eoi_rot            = ROTATE;
        rot_lvl            = EOI_LEVEL;
      end else if (isr_vld) begin
        isr_clr[hp_isr] = 1'b1;
        eoi_rot         = ROTATE;
        rot_lvl         = hp_isr;
      end
    end

    if (PRIO_CMD)      lp_d = EOI_LEVEL;
    else if (eoi_rot)  lp_d = rot_lvl;
    else if (aeoi_rot) lp_d = ir_num_q;

    // Clears come from the current ISR; a same-cycle acknowledge set wins.
    isr_d = (isr_q & ~isr_clr) | isr_set;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      irr_q       <= '0;
      isr_q       <= '0;
      ir_prev_q   <= '1;
      inta_prev_q <= 1'b1;
      ack_q       <= ACK_IDLE;
      spur_q      <= 1'b0;
      int_q       <= 1'b0;
      ir_num_q    <= 3'd0;
      lp_q        <= 3'd7;
    end else begin
      irr_q       <= irr_d;
      isr_q       <= isr_d;
      ir_prev_q   <= ir_prev_d;
      inta_prev_q <= inta_prev_d;
      ack_q       <= ack_d;
      spur_q      <= spur_d;
      int_q       <= int_d;
      ir_num_q    <= ir_num_d;
      lp_q        <= lp_d;
    end
  end

  assign INTERNAL_INT = int_q;
  assign IR_NUM       = ir_num_q;
  assign IRR_OUT      = irr_q;
  assign ISR_OUT      = isr_q;

endmodule

// File: tb/tb_pic_priority_resolver.sv
// Directed bench for pic_priority_resolver: a behavioural reference model
// checked every cycle, plus literal expectations at key points.
module tb_pic_priority_resolver;

  logic       clk = 1'b0;
  logic       RESET = 1'b1;
  logic [7:0] IR = 8'h00;
  logic       LEVEL = 1'b0;
  logic [7:0] interrupt_mask = 8'h00;
  logic       INTA_ = 1'b1;
  logic       AEOI = 1'b0;
  logic       R = 1'b0;
  logic       EOI_CMD = 1'b0;
  logic       SEOI = 1'b0;
  logic       ROTATE = 1'b0;
  logic       PRIO_CMD = 1'b0;
  logic [2:0] EOI_LEVEL = 3'd0;
  logic       INTERNAL_INT;
  logic [2:0] IR_NUM;
  logic [7:0] IRR_OUT, ISR_OUT;

  int vectors = 0;
  int miscompares = 0;

  pic_priority_resolver #(.NUM_IR(8)) dut (
    .CLK(clk), .RESET(RESET), .IR(IR), .LEVEL(LEVEL),
    .interrupt_mask(interrupt_mask), .INTA_(INTA_), .AEOI(AEOI), .R(R),
    .EOI_CMD(EOI_CMD), .SEOI(SEOI), .ROTATE(ROTATE), .PRIO_CMD(PRIO_CMD),
    .EOI_LEVEL(EOI_LEVEL), .INTERNAL_INT(INTERNAL_INT), .IR_NUM(IR_NUM),
    .IRR_OUT(IRR_OUT), .ISR_OUT(ISR_OUT)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: state kept as plain integers/vectors.
  logic [7:0] m_irr, m_isr, m_irprev;
  int         m_lp, m_irnum;
  bit         m_ack, m_spur, m_intaprev, m_int, m_ok = 1'b0;

  function automatic int rank(input int lvl, input int lp);
    return (lvl - lp - 1) & 7;
  endfunction

  function automatic int best(input logic [7:0] v, input int lp);
    int b = -1;
    int br = 8;
    for (int i = 0; i < 8; i++)
      if (v[i] && rank(i, lp) < br) begin
        br = rank(i, lp);
        b = i;
      end
    return b;
  endfunction

  always @(posedge clk) begin
    logic [7:0] pend, n_irr, n_isr, clr, setb;
    int hpp, hpi, n_lp, n_irnum, eoi_lvl, aeoi_lvl;
    bit n_ack, n_spur, req;
    if (RESET) begin
      m_irr <= 8'h00; m_isr <= 8'h00; m_irprev <= 8'hFF; m_lp <= 7;
      m_intaprev <= 1'b1; m_ack <= 1'b0; m_spur <= 1'b0; m_int <= 1'b0;
      m_irnum <= 0; m_ok <= 1'b1;
    end else begin
      pend = m_irr & ~interrupt_mask;
      hpp = best(pend, m_lp);
      hpi = best(m_isr, m_lp);
      req = (hpp >= 0) && (hpi < 0 || rank(hpp, m_lp) < rank(hpi, m_lp));
      n_irr = m_irr;
      for (int i = 0; i < 8; i++) begin
        if (!IR[i]) n_irr[i] = 1'b0;
        else if (LEVEL || !m_irprev[i]) n_irr[i] = 1'b1;
      end
      clr = 8'h00; setb = 8'h00; n_ack = m_ack; n_spur = m_spur;
      n_irnum = m_irnum; n_lp = m_lp; eoi_lvl = -1; aeoi_lvl = -1;
      if (m_intaprev && !INTA_) begin
        if (!m_ack) begin
          n_ack = 1'b1;
          if (hpp >= 0) begin
            n_irnum = hpp; setb[hpp] = 1'b1; n_irr[hpp] = 1'b0; n_spur = 1'b0;
          end else begin
            n_irnum = 7; n_spur = 1'b1;
          end
        end else begin
          n_ack = 1'b0;
          if (AEOI && !m_spur) begin
            clr[m_irnum] = 1'b1;
            if (R) aeoi_lvl = m_irnum;
          end
        end
      end
      if (EOI_CMD) begin
        if (SEOI) begin
          clr[EOI_LEVEL] = 1'b1;
          if (ROTATE) eoi_lvl = EOI_LEVEL;
        end else if (hpi >= 0) begin
          clr[hpi] = 1'b1;
          if (ROTATE) eoi_lvl = hpi;
        end
      end
      if (PRIO_CMD) n_lp = EOI_LEVEL;
      else if (eoi_lvl >= 0) n_lp = eoi_lvl;
      else if (aeoi_lvl >= 0) n_lp = aeoi_lvl;
      n_isr = (m_isr & ~clr) | setb;
      m_irr <= n_irr; m_isr <= n_isr; m_irprev <= IR; m_intaprev <= INTA_;
      m_ack <= n_ack; m_spur <= n_spur; m_irnum <= n_irnum; m_lp <= n_lp;
      m_int <= req && !m_ack;
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      check("model_int", {7'd0, INTERNAL_INT}, {7'd0, m_int});
      check("model_irnum", {5'd0, IR_NUM}, 8'(m_irnum));
      check("model_irr", IRR_OUT, m_irr);
      check("model_isr", ISR_OUT, m_isr);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic inta_pulse();
    INTA_ = 1'b0; tick(1);
    INTA_ = 1'b1; tick(1);
  endtask

  task automatic eoi(input bit specific, input logic [2:0] lvl);
    EOI_CMD = 1'b1; SEOI = specific; EOI_LEVEL = lvl; tick(1);
    EOI_CMD = 1'b0; SEOI = 1'b0; tick(1);
  endtask

  initial begin
    tick(2);
    RESET = 1'b0; tick(1);
    check("rst_isr", ISR_OUT, 8'h00);
    check("rst_irr", IRR_OUT, 8'h00);
    check("rst_int", {7'd0, INTERNAL_INT}, 8'h00);
    check("rst_irnum", {5'd0, IR_NUM}, 8'h00);

    // 1: edge-triggered IR2
    IR = 8'h04; tick(1);
    check("t1_int_latency", {7'd0, INTERNAL_INT}, 8'h00);
    tick(1);
    check("t1_int", {7'd0, INTERNAL_INT}, 8'h01);
    inta_pulse(); inta_pulse();
    check("t1_irnum", {5'd0, IR_NUM}, 8'h02);
    check("t1_isr", ISR_OUT, 8'h04);
    check("t1_irr", IRR_OUT, 8'h00);

    // 2: fully nested
    IR = 8'h24; tick(2);
    check("t2_no_int", {7'd0, INTERNAL_INT}, 8'h00);
    IR = 8'h26; tick(2);
    check("t2_int", {7'd0, INTERNAL_INT}, 8'h01);
    inta_pulse(); inta_pulse();
    check("t2_isr_nest", ISR_OUT, 8'h06);
    eoi(1'b0, 3'd0);
    check("t2_isr_eoi", ISR_OUT, 8'h04);
    IR = 8'h00; eoi(1'b1, 3'd2);
    check("t2_isr_clean", ISR_OUT, 8'h00);

    // 3: mask
    interrupt_mask = 8'h01; IR = 8'h01; tick(2);
    check("t3_irr", IRR_OUT, 8'h01);
    check("t3_masked", {7'd0, INTERNAL_INT}, 8'h00);
    interrupt_mask = 8'h00; tick(1);
    check("t3_unmasked", {7'd0, INTERNAL_INT}, 8'h01);
    inta_pulse(); inta_pulse();
    IR = 8'h00; eoi(1'b0, 3'd0);

    // 4: auto-EOI with rotation
    AEOI = 1'b1; R = 1'b1; IR = 8'h08; tick(2);
    inta_pulse();
    check("t4_isr_mid", ISR_OUT, 8'h08);
    inta_pulse();
    check("t4_isr_aeoi", ISR_OUT, 8'h00);
    IR = 8'h00; tick(1);
    IR = 8'h14; tick(2);
    inta_pulse();
    check("t4_rot_irnum", {5'd0, IR_NUM}, 8'h04);
    inta_pulse();
    IR = 8'h00; AEOI = 1'b0; R = 1'b0;
    PRIO_CMD = 1'b1; EOI_LEVEL = 3'd7; tick(1);
    PRIO_CMD = 1'b0; tick(1);

    // 5: level mode and spurious
    LEVEL = 1'b1; IR = 8'h40; tick(2);
    check("t5_int", {7'd0, INTERNAL_INT}, 8'h01);
    inta_pulse(); inta_pulse();
    check("t5_isr", ISR_OUT, 8'h40);
    check("t5_irr_relevel", IRR_OUT, 8'h40);
    eoi(1'b1, 3'd6);
    check("t5_reassert", {7'd0, INTERNAL_INT}, 8'h01);
    IR = 8'h00; tick(2);
    inta_pulse();
    check("t5_spurious", {5'd0, IR_NUM}, 8'h07);
    check("t5_spur_isr", ISR_OUT, 8'h00);
    inta_pulse();

    // 6: reset between INTA_ pulses
    LEVEL = 1'b0; IR = 8'h02; tick(2);
    inta_pulse();
    check("t6_isr_pre", ISR_OUT, 8'h02);
    RESET = 1'b1; tick(1);
    RESET = 1'b0; tick(1);
    check("t6_isr_rst", ISR_OUT, 8'h00);
    IR = 8'h0A; tick(2);
    inta_pulse();
    check("t6_irnum", {5'd0, IR_NUM}, 8'h03);
    check("t6_isr", ISR_OUT, 8'h08);
    inta_pulse();
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
